// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and requester ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin picker; req_i[0] is the CPU, req_i[1] the host.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       winner_o
);

  // on a tie the port that did not win last time gets the memory
  always_comb begin
    valid_o = |req_i;
    case (req_i)
      2'b01:   winner_o = REQ_CPU;
      2'b10:   winner_o = REQ_HOST;
      2'b11:   winner_o = ~last_i;
      default: winner_o = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// CPU/host arbiter for the shared synchronous memory: one transaction at a time.
// Optional build macro MEM_ARB_LOCK_EN adds host_lock_i, which blocks CPU requests.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
`ifdef MEM_ARB_LOCK_EN
  input  logic              host_lock_i,
`endif
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_done_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_done_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e              state_q, state_d;
  logic                win_q, win_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
  logic                cpu_gnt_q, cpu_gnt_d, host_gnt_q, host_gnt_d;
  logic                cpu_done_q, cpu_done_d, host_done_q, host_done_d;
  logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [1:0]          elig_s;
  logic                pick_valid_s, pick_win_s;

`ifdef MEM_ARB_LOCK_EN
  assign elig_s = {host_req_i, cpu_req_i & ~host_lock_i};
`else
  assign elig_s = {host_req_i, cpu_req_i};
`endif

  mem_arb_rr_pick u_pick (
    .req_i    (elig_s),
    .last_i   (last_q),
    .valid_o  (pick_valid_s),
    .winner_o (pick_win_s)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid_s) state_d = ISSUE; else state_d = IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = DONE; else state_d = WAIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // transaction latch, wait counter, round-robin pointer and read-data capture
  always_comb begin
    win_d        = win_q;
    last_d       = last_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          win_d = pick_win_s;
          if (pick_win_s == REQ_HOST) begin
            we_d = host_we_i; addr_d = host_addr_i; wdata_d = host_wdata_i;
          end else begin
            we_d = cpu_we_i;  addr_d = cpu_addr_i;  wdata_d = cpu_wdata_i;
          end
        end else begin
          win_d = win_q;
        end
      end
      ISSUE: cnt_d = CNT_W'(MEM_LAT - 1);
      WAIT: begin
        if (cnt_q == '0) begin
          last_d = win_q;
          if (we_q) begin
            cpu_rdata_d = cpu_rdata_q;
          end else if (win_q == REQ_HOST) begin
            host_rdata_d = mem_rdata_i;
          end else begin
            cpu_rdata_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // FSM outputs, derived from the next state so they register in step with it
  always_comb begin
    if (state_d != IDLE) begin
      cpu_gnt_d  = (win_d == REQ_CPU);
      host_gnt_d = (win_d == REQ_HOST);
    end else begin
      cpu_gnt_d  = 1'b0;
      host_gnt_d = 1'b0;
    end
    cpu_done_d  = (state_d == DONE) && (win_d == REQ_CPU);
    host_done_d = (state_d == DONE) && (win_d == REQ_HOST);
    mem_en_d    = (state_d == ISSUE);
    mem_we_d    = (state_d == ISSUE) && we_d;
  end

  // datapath and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      win_q <= REQ_CPU;        last_q <= REQ_HOST;
      we_q <= 1'b0;            addr_q <= '0;           wdata_q <= '0;
      cnt_q <= '0;             cpu_rdata_q <= '0;      host_rdata_q <= '0;
      cpu_gnt_q <= 1'b0;       host_gnt_q <= 1'b0;
      cpu_done_q <= 1'b0;      host_done_q <= 1'b0;
      mem_en_q <= 1'b0;        mem_we_q <= 1'b0;
    end else begin
      win_q <= win_d;          last_q <= last_d;
      we_q <= we_d;            addr_q <= addr_d;       wdata_q <= wdata_d;
      cnt_q <= cnt_d;          cpu_rdata_q <= cpu_rdata_d;  host_rdata_q <= host_rdata_d;
      cpu_gnt_q <= cpu_gnt_d;  host_gnt_q <= host_gnt_d;
      cpu_done_q <= cpu_done_d; host_done_q <= host_done_d;
      mem_en_q <= mem_en_d;    mem_we_q <= mem_we_d;
    end
  end

  assign cpu_gnt_o    = cpu_gnt_q;
  assign host_gnt_o   = host_gnt_q;
  assign cpu_done_o   = cpu_done_q;
  assign host_done_o  = host_done_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign host_rdata_o = host_rdata_q;
  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: one MEM_LAT=1 and one MEM_LAT=3 instance.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, host_lock;
  logic       cpu_req, cpu_we, host_req, host_we;
  logic [7:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic       cpu_gnt, cpu_done, host_gnt, host_done, mem_en, mem_we;
  logic [7:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;

  logic       c3_req, c3_we, h3_req, h3_we;
  logic [7:0] c3_addr, c3_wdata, h3_addr, h3_wdata;
  logic       c3_gnt, c3_done, h3_gnt, h3_done, m3_en, m3_we;
  logic [7:0] c3_rdata, h3_rdata, m3_addr, m3_wdata, m3_rdata;

  logic       pl_we;
  logic [7:0] pl_addr, pl_data;
  logic [7:0] mem1 [256];
  logic [7:0] m1_rd, r1, r2, r3;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
`ifdef MEM_ARB_LOCK_EN
    .host_lock_i(host_lock),
`endif
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_done_o(cpu_done), .cpu_rdata_o(cpu_rdata),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_gnt_o(host_gnt), .host_done_o(host_done), .host_rdata_o(host_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
`ifdef MEM_ARB_LOCK_EN
    .host_lock_i(1'b0),
`endif
    .cpu_req_i(c3_req), .cpu_we_i(c3_we), .cpu_addr_i(c3_addr), .cpu_wdata_i(c3_wdata),
    .cpu_gnt_o(c3_gnt), .cpu_done_o(c3_done), .cpu_rdata_o(c3_rdata),
    .host_req_i(h3_req), .host_we_i(h3_we), .host_addr_i(h3_addr), .host_wdata_i(h3_wdata),
    .host_gnt_o(h3_gnt), .host_done_o(h3_done), .host_rdata_o(h3_rdata),
    .mem_en_o(m3_en), .mem_we_o(m3_we), .mem_addr_o(m3_addr), .mem_wdata_o(m3_wdata),
    .mem_rdata_i(m3_rdata)
  );

  // latency-1 synchronous RAM with a bench-side preload port
  always @(posedge clk) begin
    if (pl_we) mem1[pl_addr] <= pl_data;
    else if (mem_en && mem_we) mem1[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) m1_rd <= mem1[mem_addr];
  end
  assign mem_rdata = m1_rd;

  // latency-3 read-only memory whose content is addr ^ 0x3E
  always @(posedge clk) begin
    if (m3_en) r1 <= m3_addr ^ 8'h3E;
    r2 <= r1;
    r3 <= r2;
  end
  assign m3_rdata = r3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; host_lock = 1'b0; pl_we = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    c3_req = 1'b0; c3_we = 1'b0; c3_addr = 8'h00; c3_wdata = 8'h00;
    h3_req = 1'b0; h3_we = 1'b0; h3_addr = 8'h00; h3_wdata = 8'h00;
    tick(); tick();
    preload(8'h12, 8'hA5);
    preload(8'h20, 8'h11);
    preload(8'h21, 8'h22);
    total++;
    if ({cpu_gnt, host_gnt, cpu_done, host_done, mem_en, mem_we} !== 6'b000000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000000", {cpu_gnt, host_gnt, cpu_done, host_done, mem_en, mem_we});
    end
    total++;
    if ({mem_addr, mem_wdata, cpu_rdata, host_rdata} !== 32'h0) begin
      bad++; $display("FAIL reset_data got=%h want=00000000", {mem_addr, mem_wdata, cpu_rdata, host_rdata});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
    total++;
    if ({mem_en, cpu_gnt} !== 2'b00) begin
      bad++; $display("FAIL rd_cyc0 got=%b want=00", {mem_en, cpu_gnt});
    end
    tick();
    total++;
    if ({mem_en, mem_we, cpu_gnt, host_gnt, mem_addr} !== {4'b1010, 8'h12}) begin
      bad++; $display("FAIL rd_issue got=%b_%h want=1010_12", {mem_en, mem_we, cpu_gnt, host_gnt}, mem_addr);
    end
    tick();
    total++;
    if ({mem_en, cpu_gnt, cpu_done} !== 3'b010) begin
      bad++; $display("FAIL rd_wait got=%b want=010", {mem_en, cpu_gnt, cpu_done});
    end
    tick();
    total++;
    if ({cpu_done, cpu_gnt, cpu_rdata} !== {2'b11, 8'hA5}) begin
      bad++; $display("FAIL rd_done got=%b_%h want=11_a5", {cpu_done, cpu_gnt}, cpu_rdata);
    end
    cpu_req = 1'b0;
    tick();
    total++;
    if ({cpu_done, cpu_gnt, cpu_rdata, mem_addr} !== {2'b00, 8'hA5, 8'h12}) begin
      bad++; $display("FAIL rd_after got=%b_%h_%h want=00_a5_12", {cpu_done, cpu_gnt}, cpu_rdata, mem_addr);
    end
  endtask

  task automatic test_mid_reset();
    cpu_req = 1'b1; cpu_addr = 8'h12; cpu_we = 1'b0;
    tick(); tick();
    rst_n = 1'b0; cpu_req = 1'b0;
    tick(); tick();
    total++;
    if ({cpu_gnt, host_gnt, cpu_done, host_done, mem_en, mem_we, mem_addr, cpu_rdata} !== 22'h0) begin
      bad++; $display("FAIL midrst got=%b_%h_%h want=0", {cpu_gnt, host_gnt, cpu_done, host_done, mem_en, mem_we}, mem_addr, cpu_rdata);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if ({mem_en, cpu_gnt, cpu_done} !== 3'b000) begin
      bad++; $display("FAIL midrst_after got=%b want=000", {mem_en, cpu_gnt, cpu_done});
    end
  endtask

  task automatic test_round_robin();
    int t = 0;
    int last_t = 0;
    int got = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h21;
    while (got < 4 && t < 40) begin
      tick(); t++;
      total++;
      if (cpu_gnt && host_gnt) begin
        bad++; $display("FAIL rr_two_gnt got=11 want=one at t=%0d", t);
      end
      if (cpu_done || host_done) begin
        total++;
        if ({cpu_done, host_done} !== ((got % 2 == 0) ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL rr_order n=%0d got=%b want=%b", got, {cpu_done, host_done}, (got % 2 == 0) ? 2'b10 : 2'b01);
        end
        total++;
        if (t - last_t != ((got == 0) ? 3 : 4)) begin
          bad++; $display("FAIL rr_gap n=%0d got=%0d want=%0d", got, t - last_t, (got == 0) ? 3 : 4);
        end
        total++;
        if ({cpu_rdata, host_rdata} !== ((got == 0) ? 16'hA511 : 16'h1122) && got != 0) begin
          bad++; $display("FAIL rr_rdata n=%0d got=%h want=1122", got, {cpu_rdata, host_rdata});
        end
        last_t = t;
        got++;
      end
    end
    total++;
    if (got != 4) begin
      bad++; $display("FAIL rr_timeout got=%0d want=4", got);
    end
    cpu_req = 1'b0; host_req = 1'b0;
    tick();
  endtask

  task automatic test_host_write_cpu_read();
    int n = 0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h3C;
    tick();
    total++;
    if ({mem_en, mem_we, host_gnt, cpu_gnt, mem_addr, mem_wdata} !== {4'b1110, 8'h40, 8'h3C}) begin
      bad++; $display("FAIL wr_issue got=%b_%h_%h want=1110_40_3c", {mem_en, mem_we, host_gnt, cpu_gnt}, mem_addr, mem_wdata);
    end
    tick(); tick();
    total++;
    if ({host_done, host_rdata} !== {1'b1, 8'h22}) begin
      bad++; $display("FAIL wr_done got=%b_%h want=1_22", host_done, host_rdata);
    end
    host_req = 1'b0; host_we = 1'b0;
    tick();
    total++;
    if (mem1[8'h40] !== 8'h3C) begin
      bad++; $display("FAIL wr_mem got=%h want=3c", mem1[8'h40]);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h40;
    while (!cpu_done && n < 10) begin
      tick(); n++;
    end
    total++;
    if ({cpu_done, cpu_rdata, host_rdata} !== {1'b1, 8'h3C, 8'h22}) begin
      bad++; $display("FAIL wr_readback got=%b_%h_%h want=1_3c_22", cpu_done, cpu_rdata, host_rdata);
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_lat3();
    c3_req = 1'b1; c3_we = 1'b0; c3_addr = 8'h55;
    total++;
    if ({m3_en, c3_gnt} !== 2'b00) begin
      bad++; $display("FAIL l3_cyc0 got=%b want=00", {m3_en, c3_gnt});
    end
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 2) c3_req = 1'b0;
      total++;
      if ({m3_en, c3_gnt, c3_done} !== {c == 1, c >= 1 && c <= 5, c == 5}) begin
        bad++; $display("FAIL l3_seq cyc=%0d got=%b want=%b", c, {m3_en, c3_gnt, c3_done}, {c == 1, c >= 1 && c <= 5, c == 5});
      end
      if (c == 5) begin
        total++;
        if (c3_rdata !== 8'h6B) begin
          bad++; $display("FAIL l3_rdata got=%h want=6b", c3_rdata);
        end
      end
    end
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock();
    int t = 0;
    int got = 0;
    host_lock = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h21;
    while (got < 4 && t < 40) begin
      tick(); t++;
      if (got < 3) begin
        total++;
        if (cpu_gnt) begin
          bad++; $display("FAIL lock_cpu_gnt got=1 want=0 t=%0d", t);
        end
      end
      if (cpu_done || host_done) begin
        total++;
        if ({cpu_done, host_done} !== ((got < 3) ? 2'b01 : 2'b10)) begin
          bad++; $display("FAIL lock_order n=%0d got=%b want=%b", got, {cpu_done, host_done}, (got < 3) ? 2'b01 : 2'b10);
        end
        got++;
        if (got == 3) host_lock = 1'b0;
      end
    end
    total++;
    if (got != 4) begin
      bad++; $display("FAIL lock_timeout got=%0d want=4", got);
    end
    cpu_req = 1'b0; host_req = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_read();
    test_mid_reset();
    test_round_robin();
    test_host_write_cpu_read();
    test_lat3();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
